// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
// Package : clock_pkg
// Brief   : Shared terminal values and mode encodings for the 24 h clock
//           datapath (seconds, minutes and hours stages).
// Rev     : 1.0  initial release
// ============================================================================
package clock_pkg;

  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [4:0] HOUR_MAX = 5'd23;
  localparam logic [5:0] SEC_MAX  = 6'd59;

  // MODE_BAD is never entered on purpose; it exists so the FSM can name the
  // spare code and steer it back to RUN.
  typedef enum logic [1:0] {
    MODE_RUN     = 2'b00,
    MODE_SET_HR  = 2'b01,
    MODE_SET_MIN = 2'b10,
    MODE_BAD     = 2'b11
  } mode_e;

endpackage : clock_pkg
`default_nettype wire

// File: rtl/bin2bcd_6.sv
`default_nettype none
// ============================================================================
// Module : bin2bcd_6
// Brief  : Combinational 6-bit binary (0..63) to two-digit BCD {tens, ones}.
// Rev    : 1.0  initial release
// ============================================================================
module bin2bcd_6 (
  input  logic [5:0] i_bin,
  output logic [7:0] o_bcd
);

  logic [3:0] w_tens;
  logic [3:0] w_ones;

  // Range compare against each decade; the remainder always fits in 4 bits.
  always_comb begin
    w_tens = 4'd0;
    w_ones = i_bin[3:0];
    if (i_bin >= 6'd60) begin
      w_tens = 4'd6;
      w_ones = 4'(i_bin - 6'd60);
    end else if (i_bin >= 6'd50) begin
      w_tens = 4'd5;
      w_ones = 4'(i_bin - 6'd50);
    end else if (i_bin >= 6'd40) begin
      w_tens = 4'd4;
      w_ones = 4'(i_bin - 6'd40);
    end else if (i_bin >= 6'd30) begin
      w_tens = 4'd3;
      w_ones = 4'(i_bin - 6'd30);
    end else if (i_bin >= 6'd20) begin
      w_tens = 4'd2;
      w_ones = 4'(i_bin - 6'd20);
    end else if (i_bin >= 6'd10) begin
      w_tens = 4'd1;
      w_ones = 4'(i_bin - 6'd10);
    end
    o_bcd = {w_tens, w_ones};
  end

endmodule : bin2bcd_6
`default_nettype wire

// File: rtl/min_hour_counter.sv
`default_nettype none
// ============================================================================
// Module : min_hour_counter
// Brief  : Minutes/hours stage of the 24 h clock. Advances on the seconds
//          tick in RUN, lets the user set hours/minutes with two buttons,
//          and emits a one-cycle day_tick at midnight rollover.
// Rev    : 1.0  initial release
// ============================================================================
module min_hour_counter
  import clock_pkg::*;
#(
  parameter logic [5:0] MIN_MAX  = clock_pkg::MIN_MAX,
  parameter logic [4:0] HOUR_MAX = clock_pkg::HOUR_MAX
) (
  input  logic       clk_1Hz,
  input  logic       rst,
  input  logic       tick,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [5:0] minutes,
  output logic [4:0] hours,
  output logic [7:0] min_bcd,
  output logic [7:0] hr_bcd,
  output logic       day_tick,
  output logic [1:0] mode
);

  mode_e      r_state;
  mode_e      w_state_nxt;

  logic       r_mode_btn_q;
  logic       r_inc_btn_q;
  logic       w_mode_edge;
  logic       w_inc_edge;

  logic [5:0] r_min;
  logic [4:0] r_hr;
  logic [7:0] r_min_bcd;
  logic [7:0] r_hr_bcd;
  logic       r_day;

  logic [5:0] w_min_nxt;
  logic [4:0] w_hr_nxt;
  logic       w_day_nxt;
  logic [5:0] w_min_inc;
  logic [4:0] w_hr_inc;
  logic [7:0] w_min_bcd_nxt;
  logic [7:0] w_hr_bcd_nxt;

  // Button history resets high so a button held through reset gives no edge.
  always_ff @(posedge clk_1Hz) begin
    if (rst) begin
      r_mode_btn_q <= 1'b1;
      r_inc_btn_q  <= 1'b1;
    end else begin
      r_mode_btn_q <= mode_btn;
      r_inc_btn_q  <= inc_btn;
    end
  end

  assign w_mode_edge = mode_btn & ~r_mode_btn_q;
  assign w_inc_edge  = inc_btn  & ~r_inc_btn_q;

  // Wrapping increments at native width; shared by RUN carry and SET modes.
  assign w_min_inc = (r_min == MIN_MAX)  ? 6'd0 : r_min + 6'd1;
  assign w_hr_inc  = (r_hr  == HOUR_MAX) ? 5'd0 : r_hr  + 5'd1;

  // Mode state register.
  always_ff @(posedge clk_1Hz) begin
    if (rst) begin
      r_state <= MODE_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next mode and next time: the field update for the current mode is
  // applied even when the mode button advances the state on the same edge.
  always_comb begin
    w_state_nxt = r_state;
    w_min_nxt   = r_min;
    w_hr_nxt    = r_hr;
    w_day_nxt   = 1'b0;
    case (r_state)
      MODE_RUN: begin
        if (tick) begin
          w_min_nxt = w_min_inc;
          if (r_min == MIN_MAX) begin
            w_hr_nxt  = w_hr_inc;
            w_day_nxt = (r_hr == HOUR_MAX);
          end
        end
        if (w_mode_edge) begin
          w_state_nxt = MODE_SET_HR;
        end
      end
      MODE_SET_HR: begin
        if (w_inc_edge) begin
          w_hr_nxt = w_hr_inc;
        end
        if (w_mode_edge) begin
          w_state_nxt = MODE_SET_MIN;
        end
      end
      MODE_SET_MIN: begin
        if (w_inc_edge) begin
          w_min_nxt = w_min_inc;
        end
        if (w_mode_edge) begin
          w_state_nxt = MODE_RUN;
        end
      end
      default: begin
        w_state_nxt = MODE_RUN;
      end
    endcase
  end

  // BCD is derived from the next-state values so it moves with the binary.
  bin2bcd_6 u_min_bcd (
    .i_bin (w_min_nxt),
    .o_bcd (w_min_bcd_nxt)
  );

  bin2bcd_6 u_hr_bcd (
    .i_bin ({1'b0, w_hr_nxt}),
    .o_bcd (w_hr_bcd_nxt)
  );

  // Time, BCD and day pulse registers.
  always_ff @(posedge clk_1Hz) begin
    if (rst) begin
      r_min     <= 6'd0;
      r_hr      <= 5'd0;
      r_min_bcd <= 8'h00;
      r_hr_bcd  <= 8'h00;
      r_day     <= 1'b0;
    end else begin
      r_min     <= w_min_nxt;
      r_hr      <= w_hr_nxt;
      r_min_bcd <= w_min_bcd_nxt;
      r_hr_bcd  <= w_hr_bcd_nxt;
      r_day     <= w_day_nxt;
    end
  end

  assign minutes  = r_min;
  assign hours    = r_hr;
  assign min_bcd  = r_min_bcd;
  assign hr_bcd   = r_hr_bcd;
  assign day_tick = r_day;
  assign mode     = r_state;

endmodule : min_hour_counter
`default_nettype wire

// File: tb/tb_min_hour_counter.sv
`default_nettype none
// ============================================================================
// Module : tb_min_hour_counter
// Brief  : Self-checking bench for min_hour_counter. Each step pushes the
//          expected post-edge state onto a queue, clocks once and pops it.
// Rev    : 1.0  initial release
// ============================================================================
module tb_min_hour_counter;

  logic       clk_1Hz;
  logic       rst;
  logic       tick;
  logic       mode_btn;
  logic       inc_btn;
  logic [5:0] minutes;
  logic [4:0] hours;
  logic [7:0] min_bcd;
  logic [7:0] hr_bcd;
  logic       day_tick;
  logic [1:0] mode;

  min_hour_counter dut (
    .clk_1Hz  (clk_1Hz),
    .rst      (rst),
    .tick     (tick),
    .mode_btn (mode_btn),
    .inc_btn  (inc_btn),
    .minutes  (minutes),
    .hours    (hours),
    .min_bcd  (min_bcd),
    .hr_bcd   (hr_bcd),
    .day_tick (day_tick),
    .mode     (mode)
  );

  initial clk_1Hz = 1'b0;
  always #5 clk_1Hz = ~clk_1Hz;

  typedef struct packed {
    logic [5:0] mn;
    logic [4:0] hr;
    logic [1:0] md;
    logic       dy;
  } exp_t;

  exp_t  sb[$];
  int    n_checks = 0;
  int    n_errors = 0;
  string tag = "reset";

  // Reference state, written from the clock's user-visible rules.
  int   m_min  = 0;
  int   m_hr   = 0;
  int   m_mode = 0;
  logic m_day  = 1'b0;
  logic m_pm   = 1'b1;
  logic m_pi   = 1'b1;

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    assert (got === want) else begin
      n_errors++;
      $error("FAIL %s/%s: observed %0d expected %0d", tag, name, got, want);
    end
  endtask

  // One clock: apply inputs, predict, clock, compare every output.
  task automatic step(input logic r, input logic t, input logic m, input logic i);
    logic me;
    logic ie;
    exp_t e;
    exp_t g;
    me = m & ~m_pm;
    ie = i & ~m_pi;
    if (r) begin
      m_min = 0; m_hr = 0; m_mode = 0; m_day = 1'b0;
      m_pm = 1'b1; m_pi = 1'b1;
    end else begin
      m_pm  = m;
      m_pi  = i;
      m_day = 1'b0;
      if (m_mode == 0) begin
        if (t) begin
          if (m_min == 59) begin
            m_min = 0;
            if (m_hr == 23) begin
              m_hr  = 0;
              m_day = 1'b1;
            end else begin
              m_hr = m_hr + 1;
            end
          end else begin
            m_min = m_min + 1;
          end
        end
        if (me) m_mode = 1;
      end else if (m_mode == 1) begin
        if (ie) m_hr = (m_hr == 23) ? 0 : m_hr + 1;
        if (me) m_mode = 2;
      end else begin
        if (ie) m_min = (m_min == 59) ? 0 : m_min + 1;
        if (me) m_mode = 0;
      end
    end
    e.mn = 6'(m_min);
    e.hr = 5'(m_hr);
    e.md = 2'(m_mode);
    e.dy = m_day;
    sb.push_back(e);
    rst = r; tick = t; mode_btn = m; inc_btn = i;
    @(posedge clk_1Hz);
    #1;
    n_checks++;
    assert (sb.size() != 0) else begin
      n_errors++;
      $error("FAIL %s/scoreboard: observed empty queue expected one entry", tag);
    end
    if (sb.size() != 0) begin
      g = sb.pop_front();
      chk("minutes",  int'(minutes),  int'(g.mn));
      chk("hours",    int'(hours),    int'(g.hr));
      chk("mode",     int'(mode),     int'(g.md));
      chk("day_tick", int'(day_tick), int'(g.dy));
      chk("min_bcd",  int'(min_bcd),  int'(to_bcd(int'(g.mn))));
      chk("hr_bcd",   int'(hr_bcd),   int'(to_bcd(int'(g.hr))));
    end
  endtask

  task automatic press_mode();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // n increment presses; tick is pulsed in the release cycle when t is set.
  task automatic press_inc(input int n, input logic t);
    for (int k = 0; k < n; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, t,    1'b0, 1'b0);
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Load hh:mm through the set modes and return to RUN.
  task automatic preload(input int hh, input int mm);
    do_reset();
    press_mode();
    press_inc(hh, 1'b0);
    press_mode();
    press_inc(mm, 1'b0);
    press_mode();
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0;

    tag = "reset";
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_min", int'(minutes), 0);
    chk("rst_mode", int'(mode), 0);
    chk("rst_bcd", int'({min_bcd, hr_bcd}), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    tag = "hour_run";
    for (int k = 0; k < 60; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      for (int j = 0; j < 59; j++) step(1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("min", int'(minutes), 0);
    chk("hr", int'(hours), 1);
    chk("hr_bcd", int'(hr_bcd), 8'h01);

    tag = "set_hr";
    do_reset();
    press_mode();
    chk("mode", int'(mode), 1);
    press_inc(25, 1'b1);
    chk("hr", int'(hours), 1);
    chk("min", int'(minutes), 0);

    tag = "set_min";
    press_mode();
    chk("mode", int'(mode), 2);
    press_inc(61, 1'b1);
    chk("min", int'(minutes), 1);
    chk("hr", int'(hours), 1);
    press_mode();
    chk("mode", int'(mode), 0);

    tag = "midnight";
    preload(23, 58);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("min59", int'(minutes), 59);
    for (int j = 0; j < 5; j++) step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("day_hi", int'(day_tick), 1);
    chk("bcd00", int'({min_bcd, hr_bcd}), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("day_lo", int'(day_tick), 0);

    tag = "tick_and_mode";
    preload(10, 59);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("hr", int'(hours), 11);
    chk("min", int'(minutes), 0);
    chk("mode", int'(mode), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    tag = "inc_and_mode";
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("hr", int'(hours), 12);
    chk("mode", int'(mode), 2);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    tag = "held_through_reset";
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("mode", int'(mode), 0);
    chk("hr", int'(hours), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    tag = "reset_in_set_min";
    do_reset();
    press_mode();
    press_inc(12, 1'b0);
    press_mode();
    press_inc(34, 1'b0);
    chk("pre_min", int'(minutes), 34);
    chk("pre_mode", int'(mode), 2);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("min", int'(minutes), 0);
    chk("hr", int'(hours), 0);
    chk("mode", int'(mode), 0);
    chk("bcd", int'({min_bcd, hr_bcd}), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_min_hour_counter
`default_nettype wire

// File: doc/min_hour_counter.md
Name: min_hour_counter

Overview:
- Downstream stage of the seconds counter in the 24 h clock datapath.
- Consumes the seconds counter's one-cycle `tick` (registered pulse, asserted in the cycle `seconds` reads 0), and counts minutes 0–59 and hours 0–23.
- Provides a user time-set mode driven by two buttons, plus binary and BCD outputs for the display driver.
- Emits a one-cycle `day_tick` on midnight rollover.

Parameters:
- MIN_MAX, 59, terminal minute value.
- HOUR_MAX, 23, terminal hour value.

Ports:
- clk_1Hz    in   1  clock; all state updates on its rising edge.
- rst        in   1  synchronous, active-high reset.
- tick       in   1  minute-advance pulse from the seconds counter; one cycle wide.
- mode_btn   in   1  mode button level, already synchronised/debounced.
- inc_btn    in   1  increment button level, already synchronised/debounced.
- minutes    out  6  binary minutes, 0..MIN_MAX.
- hours      out  5  binary hours, 0..HOUR_MAX.
- min_bcd    out  8  {tens, ones} BCD of minutes.
- hr_bcd     out  8  {tens, ones} BCD of hours.
- day_tick   out  1  one-cycle pulse on HOUR_MAX:MIN_MAX → 00:00 in RUN.
- mode       out  2  00 = RUN, 01 = SET_HR, 10 = SET_MIN.

Behaviour:
- Clocking and reset: `rst` is synchronous, active-high; clock is `clk_1Hz`.
  - Reset values: minutes = 0, hours = 0, min_bcd = 8'h00, hr_bcd = 8'h00, day_tick = 0, mode = RUN.
  - Button history registers reset to 1, so a button held through reset produces no edge.
- Button edges: a rising edge is `btn & ~btn_q`, with `btn_q` registered every cycle. A button must therefore be high for at least one `clk_1Hz` edge and low for at least one edge between presses.
- FSM states: RUN, SET_HR, SET_MIN. Transitions occur on a `mode_btn` edge only:
  - RUN → SET_HR
  - SET_HR → SET_MIN
  - SET_MIN → RUN
  - No other transitions. The unused encoding 11 returns to RUN next cycle.
- RUN:
  - `tick` = 1 with minutes < MIN_MAX: minutes + 1.
  - `tick` = 1 with minutes = MIN_MAX: minutes → 0; hours + 1, or hours → 0 if hours = HOUR_MAX.
  - `tick` = 1 at HOUR_MAX:MIN_MAX: both fields → 0, and `day_tick` = 1 for exactly the next cycle.
  - `inc_btn` is ignored.
- SET_HR: an `inc_btn` edge does hours + 1, wrapping HOUR_MAX → 0. `tick` is ignored (clock frozen). No carry, no `day_tick`.
- SET_MIN: an `inc_btn` edge does minutes + 1, wrapping MIN_MAX → 0. No carry into hours, no `day_tick`. `tick` is ignored.
- Simultaneous events:
  - `tick` and a `mode_btn` edge in RUN, same cycle: the increment is applied and mode → SET_HR, both on the same edge.
  - A `mode_btn` edge and an `inc_btn` edge in a SET state, same cycle: the increment applies to the current state's field, then mode advances.
- Latency:
  - minutes/hours update on the edge that samples `tick` = 1. Because `tick` is registered upstream, the minute advance is visible one `clk_1Hz` cycle after seconds shows 00. This is accepted; the display driver does not compensate.
  - BCD outputs are registered from the next-state binary values, so they change on the same edge as the binary outputs (no extra cycle).
- Width rules: all increments are computed at native width. Comparisons use `==` against the terminal value, never overflow. Out-of-range values are unreachable.
- Reset mid-operation: reset overrides `tick` and buttons in any state. Time returns to 00:00 and mode to RUN.

Decomposition:
- Package `clock_pkg`:
  - Localparams MIN_MAX = 59, HOUR_MAX = 23, SEC_MAX = 59.
  - Mode encodings MODE_RUN = 2'b00, MODE_SET_HR = 2'b01, MODE_SET_MIN = 2'b10.
- Sub-module `bin2bcd_6`: combinational 6-bit binary (0..63) → 8-bit BCD. Instantiate it twice, with hours zero-extended to 6 bits.
- Button edge detection stays inline.

Test Plan:
- Reset, then 60 `tick` pulses spaced 60 cycles apart → minutes = 0, hours = 1, hr_bcd = 8'h01, day_tick never asserted.
- Preload 23:58 via set mode, return to RUN, apply 2 ticks → 23:59, then 00:00; day_tick high exactly one cycle after the second tick; min_bcd = hr_bcd = 8'h00.
- Set-hour flow: mode edge → mode = 01; 25 inc edges from hours = 0 → hours = 1 (wrapped at 23 → 0); ticks during SET_HR leave minutes unchanged.
- Set-minute flow: two mode edges → mode = 10; 61 inc edges from minutes = 0 → minutes = 1; hours unchanged; day_tick stays 0; third mode edge → mode = 00.
- Simultaneous: at 10:59, `tick` and a mode edge in the same cycle → next cycle 11:00 with mode = 01. Button held high through reset release → no increment and mode stays 00.
- Reset asserted at 12:34 in SET_MIN → next cycle 00:00, mode = 00, day_tick = 0, BCD = 8'h00.
